// File: rtl/cnt161_sequencer_pkg.sv
// Shared definitions for the cnt161 cascade sequencer: FSM state encoding and
// default widths for the controlled counter cascade and the repeat count.
package cnt161_sequencer_pkg;

  localparam int unsigned WIDTH_DEF = 12;
  localparam int unsigned REPW_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/cnt161_sequencer_rep.sv
// rep_down_counter: REPW-bit repeat counter with load, decrement and
// is-one / is-zero flags.
//   clk_i, reset_bar_i : clock, synchronous active-low reset
//   load_i, load_val_i : load a new repeat count
//   dec_i              : decrement by one (load has priority)
//   is_one_o           : count equals 1
//   is_zero_o          : count equals 0 (free-run when loaded with 0)
module rep_down_counter #(
  parameter int unsigned REPW = 8
) (
  input  logic            clk_i,
  input  logic            reset_bar_i,
  input  logic            load_i,
  input  logic [REPW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            is_one_o,
  output logic            is_zero_o
);

  logic [REPW-1:0] cnt_q;
  logic [REPW-1:0] cnt_d;

  // Next count: load wins over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - REPW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_bar_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one_o  = (cnt_q == REPW'(1));
  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/cnt161_sequencer.sv
// Sequencer that clears, loads and runs an external cascade of 4-bit
// synchronous counter stages, reloading on ripple-carry and counting
// terminal-count events down to Done.
//   clk_i, reset_bar_i        : clock, synchronous active-low reset
//   start_i, stop_i, pause_i  : run request (IDLE only), abort, count freeze
//   preset_i, reps_i          : reload value and repeat count, captured on Start
//   cnt_rco_i                 : ripple-carry from the top cascade stage
//   cnt_clear_bar_o, cnt_load_bar_o, cnt_ent_o, cnt_enp_o, cnt_d_o : cascade control
//   busy_o, tick_o, done_o    : status (registered)
module cnt161_sequencer
  import cnt161_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned REPW  = REPW_DEF
) (
  input  logic             clk_i,
  input  logic             reset_bar_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             pause_i,
  input  logic [WIDTH-1:0] preset_i,
  input  logic [REPW-1:0]  reps_i,
  input  logic             cnt_rco_i,
  output logic             cnt_clear_bar_o,
  output logic             cnt_load_bar_o,
  output logic             cnt_ent_o,
  output logic             cnt_enp_o,
  output logic [WIDTH-1:0] cnt_d_o,
  output logic             busy_o,
  output logic             tick_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic             rep_load, rep_dec, rep_is_one, rep_is_zero;
  logic             rco_event;
  logic             clear_bar_c, load_bar_c, ent_c, enp_c;

  rep_down_counter #(.REPW(REPW)) u_rep (
    .clk_i       (clk_i),
    .reset_bar_i (reset_bar_i),
    .load_i      (rep_load),
    .load_val_i  (reps_i),
    .dec_i       (rep_dec),
    .is_one_o    (rep_is_one),
    .is_zero_o   (rep_is_zero)
  );

  // A carry only counts as a terminal-count event while not paused.
  assign rco_event = cnt_rco_i && !pause_i;

  // Next-state, status and cascade-control decode.
  always_comb begin
    state_d     = state_q;
    preset_d    = preset_q;
    tick_d      = 1'b0;
    done_d      = 1'b0;
    rep_load    = 1'b0;
    rep_dec     = 1'b0;
    clear_bar_c = 1'b1;
    load_bar_c  = 1'b1;
    ent_c       = 1'b0;
    enp_c       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          preset_d = preset_i;
          rep_load = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        clear_bar_c = 1'b0;
        state_d     = ST_LOAD;
      end
      ST_LOAD: begin
        load_bar_c = 1'b0;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        ent_c      = 1'b1;
        enp_c      = !pause_i;
        // Reload on the same edge as the carry so the period is 2^WIDTH - preset.
        load_bar_c = !rco_event;
        if (rco_event) begin
          tick_d = 1'b1;
          // A zero repeat count means free-run: never decrement, never finish.
          if (!rep_is_zero) begin
            if (rep_is_one) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              rep_dec = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort overrides every other action in an active state.
    if (state_q != ST_IDLE && stop_i) begin
      state_d = ST_IDLE;
      tick_d  = 1'b0;
      done_d  = 1'b0;
      rep_dec = 1'b0;
    end

    // Hold the cascade quiet while reset is asserted.
    if (!reset_bar_i) begin
      clear_bar_c = 1'b1;
      load_bar_c  = 1'b1;
      ent_c       = 1'b0;
      enp_c       = 1'b0;
    end
  end

  assign busy_d = (state_d != ST_IDLE);

  always_ff @(posedge clk_i) begin
    if (!reset_bar_i) begin
      state_q  <= ST_IDLE;
      preset_q <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign cnt_clear_bar_o = clear_bar_c;
  assign cnt_load_bar_o  = load_bar_c;
  assign cnt_ent_o       = ent_c;
  assign cnt_enp_o       = enp_c;
  assign cnt_d_o         = preset_q;
  assign busy_o          = busy_q;
  assign tick_o          = tick_q;
  assign done_o          = done_q;

endmodule
